// File: rtl/bus_change_monitor.sv
// Registers a sampled copy of a WIDTH-bit bus on b and queues one event per value change.
// Define CHGMON_SYNC_EN to add a two-stage synchroniser when `a` is asynchronous to clk.
module bus_change_monitor #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int TS_BITS  = 16,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    a,
    output logic [WIDTH-1:0]    b,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_value,
    output logic [WIDTH-1:0]    ev_mask,
    output logic [TS_BITS-1:0]  ev_time,
    output logic                overflow,
    input  logic                clear_ovf,
    output logic [CNT_BITS-1:0] change_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + TS_BITS;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0]   s;
    logic               primed;
    logic [TS_BITS-1:0] ts;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
    logic [AW:0]   count, count_next;
    logic          push_req, full, pop, do_push, drop;
    logic [EW-1:0] new_ev, head_next;

`ifdef CHGMON_SYNC_EN
    logic [WIDTH-1:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= a;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = a;
`endif

    // Handshake: the head event transfers on any edge where ev_valid && ev_ready;
    // ev_ready is ignored while ev_valid is low, and the head is stable until taken.
    always_comb begin
        push_req   = primed && (s != b);
        full       = (count == FULL_CNT);
        pop        = ev_valid && ev_ready;
        do_push    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        new_ev     = {s, s ^ b, ts};
        rd_next    = rd_ptr + AW'(pop);
        wr_next    = wr_ptr + AW'(do_push);
        count_next = count + (AW + 1)'(do_push) - (AW + 1)'(pop);
        // The pushed entry becomes the head when it lands in the slot rd_next points at.
        head_next  = (do_push && (rd_next == wr_ptr)) ? new_ev : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= new_ev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            b            <= '0;
            primed       <= 1'b0;
            ts           <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ev_valid     <= 1'b0;
            ev_value     <= '0;
            ev_mask      <= '0;
            ev_time      <= '0;
            overflow     <= 1'b0;
            change_count <= '0;
        end else begin
            b      <= s;
            primed <= 1'b1;
            ts     <= ts + 1'b1;
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= count_next;
            ev_valid <= (count_next != '0);
            if (count_next != '0) begin
                {ev_value, ev_mask, ev_time} <= head_next;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            if (push_req && (change_count != '1)) begin
                change_count <= change_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_change_monitor.sv
// Bench for bus_change_monitor: directed scenarios plus random traffic against an event-queue model.
module tb_bus_change_monitor;

  localparam int W   = 2;
  localparam int D   = 4;
  localparam int TSB = 16;
  localparam int CB  = 8;
  localparam int EW  = 2 * W + TSB;
`ifdef CHGMON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]   a, b, ev_value, ev_mask;
  logic           ev_valid, ev_ready, overflow, clear_ovf;
  logic [TSB-1:0] ev_time;
  logic [CB-1:0]  change_count;

  bus_change_monitor #(.WIDTH(W), .DEPTH(D), .TS_BITS(TSB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_value(ev_value),
    .ev_mask(ev_mask), .ev_time(ev_time), .overflow(overflow),
    .clear_ovf(clear_ovf), .change_count(change_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard / reference model
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  pipe[$];
  logic [W-1:0]  m_b;
  bit            m_primed;
  int            m_ts;
  int            m_cnt;
  bit            m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pipe.delete();
    for (int i = 0; i < LAT; i++) pipe.push_back('0);
    m_b = '0;
    m_primed = 0;
    m_ts = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0]  s;
    logic [EW-1:0] dummy;
    bit pop;
    bit drop;
    if (reset) begin
      model_reset();
      return;
    end
    if (LAT == 0) begin
      s = a;
    end else begin
      s = pipe.pop_front();
      pipe.push_back(a);
    end
    pop = (exp_q.size() != 0) && (ev_ready === 1'b1);
    drop = 0;
    if (pop) dummy = exp_q.pop_front();
    if (m_primed && (s != m_b)) begin
      if (m_cnt < (1 << CB) - 1) m_cnt = m_cnt + 1;
      if (exp_q.size() < D) exp_q.push_back({s, s ^ m_b, TSB'(m_ts)});
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clear_ovf) m_ovf = 0;
    m_b = s;
    m_primed = 1;
    m_ts = (m_ts + 1) % (1 << TSB);
  endtask

  // driver: one clock edge, model update, then compare away from the edge
  task automatic step();
    logic [EW-1:0] h;
    @(posedge clk);
    model_edge();
    #1;
    chk("b", 32'(b), 32'(m_b));
    chk("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("change_count", 32'(change_count), 32'(m_cnt));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("ev_value", 32'(ev_value), 32'(h[EW-1 -: W]));
      chk("ev_mask", 32'(ev_mask), 32'(h[TSB +: W]));
      chk("ev_time", 32'(ev_time), 32'(h[TSB-1:0]));
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    a = '0;
    ev_ready = 1'b0;
    clear_ovf = 1'b0;
    model_reset();
    repeat (2) step();
    chk("rst_value", 32'(ev_value), 32'd0);
    chk("rst_mask", 32'(ev_mask), 32'd0);
    chk("rst_time", 32'(ev_time), 32'd0);

    // primed edge produces no event
    reset = 1'b0;
    a = 2'b10;
    repeat (5) step();
    chk("prime_b", 32'(b), 32'd2);
    chk("prime_cnt", 32'(change_count), 32'd0);

    // single change, held until accepted
    a = 2'b11;
    repeat (LAT + 1) step();
    chk("t2_value", 32'(ev_value), 32'd3);
    chk("t2_mask", 32'(ev_mask), 32'd1);
    repeat (3) step();
    chk("t2_hold", 32'(ev_mask), 32'd1);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("t2_drained", 32'(ev_valid), 32'd0);

    // six changes into a four-entry queue
    for (int i = 0; i < 6; i++) begin
      a = a + 1'b1;
      step();
    end
    repeat (LAT) step();
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_cnt", 32'(change_count), 32'd7);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("t3_clr", 32'(overflow), 32'd0);
    ev_ready = 1'b1;
    repeat (3) step();
    chk("t3_last", 32'(ev_valid), 32'd1);
    step();
    ev_ready = 1'b0;
    chk("t3_empty", 32'(ev_valid), 32'd0);

    // full queue, push coinciding with pop
    for (int i = 0; i < 4; i++) begin
      a = a + 1'b1;
      step();
    end
    repeat (LAT) step();
    a = a + 1'b1;
    repeat (LAT) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_valid", 32'(ev_valid), 32'd1);
    ev_ready = 1'b1;
    repeat (5) step();

    // multi-bit change
    a = 2'b00;
    repeat (LAT + 2) step();
    ev_ready = 1'b0;
    a = 2'b11;
    repeat (LAT + 1) step();
    chk("t5_valid", 32'(ev_valid), 32'd1);
    chk("t5_mask", 32'(ev_mask), 32'd3);

    // reset with three queued events
    a = 2'b01;
    step();
    a = 2'b10;
    step();
    repeat (LAT) step();
    chk("t6_queued", 32'(ev_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_valid", 32'(ev_valid), 32'd0);
    chk("t6_b", 32'(b), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);

    // a->b latency
    a = 2'b10;
    repeat (5) step();
    a = 2'b01;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      lat++;
      if (b == 2'b01) break;
    end
    chk("latency", 32'(lat), 32'(LAT + 1));

    // counter saturation
    for (int i = 0; i < 600; i++) begin
      a = a + 1'b1;
      ev_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("cnt_sat", 32'(change_count), 32'd255);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) a = W'($urandom_range(0, 3));
      ev_ready  = ($urandom_range(0, 3) == 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    clear_ovf = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
